// File: rtl/addsub_pkg.sv
// Shared constants, state encoding and helpers for the arbitrated add/subtract block.
package addsub_pkg;

  localparam int unsigned WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Two's-complement overflow: both adder inputs share a sign and the sum does not.
  function automatic logic calc_ovf(input logic a_msb, input logic bx_msb, input logic s_msb);
    return (a_msb == bx_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub_4.sv
// 4-bit add/subtract unit: s = a + (b ^ {4{as}}) + as, cout is the carry out of bit 3.
module addsub_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       as,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] sum_s;

  // Ripple sum with the subtract control doubling as the carry-in.
  always_comb begin
    sum_s = {1'b0, a} + {1'b0, b ^ {4{as}}} + {4'b0000, as};
    s     = sum_s[3:0];
    cout  = sum_s[4];
  end

endmodule

// File: rtl/addsub_arb.sv
// Two-requester round-robin front end around a shared 4-bit add/subtract unit.
// Each operation walks IDLE -> EXEC -> DONE; all outputs come straight from flops.
module addsub_arb
  import addsub_pkg::*;
#(
  parameter int unsigned W = WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         as0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         as1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  state_e       state_q, state_d;
  logic         ptr_q, ptr_d;        // requester favoured when both ask
  logic         id_q, id_d;          // requester owning the in-flight op
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic         as_q, as_d;
  logic         gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic         done0_q, done0_d, done1_q, done1_d;
  logic [W-1:0] result_q, result_d;
  logic         cout_q, cout_d, ovf_q, ovf_d, busy_q, busy_d;

  logic         win_s;
  logic [W-1:0] sum_s;
  logic         carry_s;

  addsub_4 u_addsub (
    .a    (a_q),
    .b    (b_q),
    .as   (as_q),
    .s    (sum_s),
    .cout (carry_s)
  );

  // Pick the winner: a lone requester wins, a tie goes to the priority pointer.
  always_comb begin
    win_s = REQ0;
    if (req0 && req1) begin
      win_s = ptr_q;
    end else if (req1) begin
      win_s = REQ1;
    end else begin
      win_s = REQ0;
    end
  end

  // Next-state, operand latch, result capture and output pulse generation.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    as_d     = as_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = EXEC;
          id_d    = win_s;
          a_d     = (win_s == REQ1) ? a1 : a0;
          b_d     = (win_s == REQ1) ? b1 : b0;
          as_d    = (win_s == REQ1) ? as1 : as0;
          gnt0_d  = (win_s == REQ0);
          gnt1_d  = (win_s == REQ1);
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        state_d  = DONE;
        result_d = sum_s;
        cout_d   = carry_s;
        ovf_d    = calc_ovf(a_q[W-1], b_q[W-1] ^ as_q, sum_s[W-1]);
        done0_d  = (id_q == REQ0);
        done1_d  = (id_q == REQ1);
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = ~id_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops everything, including any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= REQ0;
      id_q     <= REQ0;
      a_q      <= '0;
      b_q      <= '0;
      as_q     <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      as_q     <= as_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_addsub_arb.sv
// Scoreboard bench for addsub_arb: stimulus pushes expected results, a monitor checks done pulses.
module tb_addsub_arb;

  logic       clk, rst;
  logic       req0, req1, as0, as1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done0, done1, cout, ovf, busy;
  logic [3:0] result;

  typedef struct packed {
    logic       id;
    logic [3:0] r;
    logic       c;
    logic       o;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  addsub_arb dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .as0(as0),
    .req1(req1), .a1(a1), .b1(b1), .as1(as1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .cout(cout), .ovf(ovf), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every cycle checks grant exclusivity and scores each done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
      if (done0 || done1) begin
        chk("done_exclusive", {31'd0, done0 & done1}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_id",  {31'd0, done1}, {31'd0, e.id});
          chk("result",   {28'd0, result}, {28'd0, e.r});
          chk("cout",     {31'd0, cout}, {31'd0, e.c});
          chk("ovf",      {31'd0, ovf}, {31'd0, e.o});
        end
      end
    end
  end

  task automatic chk_all_zero(input string name);
    chk(name, {20'd0, gnt0, gnt1, done0, done1, result, cout, ovf, busy}, 32'd0);
  endtask

  // One operation from a single requester, with latency and busy checks.
  task automatic issue(input logic id, input logic [3:0] a, input logic [3:0] b, input logic as,
                       input logic [3:0] er, input logic ec, input logic eo, input bit scramble);
    int k;
    exp_q.push_back('{id: id, r: er, c: ec, o: eo});
    @(posedge clk); #1;
    chk("busy_idle", {31'd0, busy}, 32'd0);
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; as1 = as; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; as0 = as; end
    for (k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if ((id && gnt1) || (!id && gnt0)) break;
    end
    chk("gnt_latency", k, 0);
    chk("busy_exec", {31'd0, busy}, 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    if (scramble) begin
      a0 = 4'hF; b0 = 4'hF; as0 = 1'b1; a1 = 4'hF; b1 = 4'hF; as1 = 1'b1;
    end
    for (k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if ((id && done1) || (!id && done0)) break;
    end
    chk("done_latency", k, 0);
    chk("busy_done", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    int n, cyc, last;
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    a0 = 4'h0; b0 = 4'h0; as0 = 1'b0; a1 = 4'h0; b1 = 4'h0; as1 = 1'b0;
    #1 rst = 1'b1;
    #2 chk_all_zero("reset_outputs");
    @(posedge clk); #1 rst = 1'b0;

    issue(1'b0, 4'd3, 4'd2, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 4'd2, 4'd3, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 4'd8, 4'd1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0);
    issue(1'b0, 4'd5, 4'd5, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 4'd4, 4'd3, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1);

    // Reset, then both requesters held high: service alternates starting at 0.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_q.push_back('{id: 1'b0, r: 4'd3, c: 1'b0, o: 1'b0});
      else            exp_q.push_back('{id: 1'b1, r: 4'd4, c: 1'b1, o: 1'b0});
    end
    a0 = 4'd1; b0 = 4'd2; as0 = 1'b0; a1 = 4'd6; b1 = 4'd2; as1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    n = 0; cyc = 0; last = 0;
    while (n < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (gnt0 || gnt1) begin
        chk("rr_order", {31'd0, gnt1}, n % 2);
        if (n > 0) chk("rr_spacing", cyc - last, 3);
        last = cyc;
        n++;
        if (n == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    chk("rr_count", n, 4);
    repeat (2) @(posedge clk);

    // Serve requester 0 so the pointer favours 1, then abort an op with reset.
    issue(1'b0, 4'd2, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd3; as0 = 1'b0;
    @(posedge clk); #1;
    chk("abort_gnt", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    #2 rst = 1'b1;
    #1 chk_all_zero("abort_outputs");
    @(posedge clk); #1;
    chk_all_zero("abort_no_done");
    rst = 1'b0;

    // Tie right after reset must go to requester 0.
    exp_q.push_back('{id: 1'b0, r: 4'd2, c: 1'b0, o: 1'b0});
    exp_q.push_back('{id: 1'b1, r: 4'd2, c: 1'b1, o: 1'b0});
    a0 = 4'd1; b0 = 4'd1; as0 = 1'b0; a1 = 4'd3; b1 = 4'd1; as1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_prio", {30'd0, gnt0, gnt1}, 32'd2);
    req0 = 1'b0;
    n = 0;
    while (!gnt1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("post_reset_second", {31'd0, gnt1}, 32'd1);
    req1 = 1'b0;

    repeat (5) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/addsub_arb.md
ADDSUB_ARB -- requirements
Module: addsub_arb

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter: W, default 4, operand/result width; only W=4 is required.
REQ-003 Ports:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- req0 / req1  in  1  request from requester 0 / 1
- a0, b0 / a1, b1  in  W  operands of requester 0 / 1
- as0 / as1  in  1  mode: 0 = add, 1 = subtract (a-b)
- gnt0 / gnt1  out  1  one-cycle accept pulse
- done0 / done1  out  1  one-cycle result-valid pulse
- result  out  W  registered sum/difference
- cout  out  1  adder carry-out; for subtract, 1 = no borrow
- ovf  out  1  signed (two's-complement) overflow
- busy  out  1  high whenever state != IDLE

Function
REQ-004 States SHALL be IDLE, EXEC, DONE; transitions IDLE->EXEC when any req is sampled high, EXEC->DONE unconditionally, DONE->IDLE unconditionally.
REQ-005 In IDLE, at the clock edge with a req high, the block SHALL latch the winner's a, b, as and winner id into internal registers.
REQ-006 Arbitration SHALL be round-robin: with one req high, that requester wins; with both high, the requester not served last wins; after reset, requester 0 has priority.
REQ-007 The priority pointer SHALL update at the DONE->IDLE edge to favour the requester not just served.
REQ-008 gntX SHALL be high for exactly the EXEC cycle of requester X's operation; at most one gnt is high in any cycle.
REQ-009 The arithmetic result SHALL be captured into result/cout/ovf at the EXEC->DONE edge:
- computation: a + (b XOR {W{as}}) + as
- cout: carry out of bit W-1
- ovf: operand MSB equals the inverted-b MSB and result MSB differs from it
REQ-010 doneX SHALL be high for exactly the DONE cycle; result/cout/ovf hold until the next capture.
REQ-011 Latency: a req sampled in IDLE at cycle N gives gnt in N+1 and done in N+2; IDLE is re-entered in N+3. Peak throughput is one operation per 3 cycles.
REQ-012 req and operand inputs SHALL be ignored in EXEC and DONE.
- A requester holds req and operands stable until its gnt.
- A req still high in the IDLE cycle after done is treated as a new request.
REQ-013 Operand changes after the latch edge SHALL NOT affect the in-flight result.
REQ-014 A losing requester SHALL keep its request pending with no loss; it is served in the next IDLE.

Reset
REQ-015 On rst assertion, regardless of clk, the block SHALL set:
- state IDLE, pointer to requester 0
- all gnt/done outputs 0
- result 0, cout 0, ovf 0, busy 0
- latched operands 0
REQ-016 A reset during EXEC or DONE SHALL discard the in-flight operation; no done is issued for it.
REQ-017 The first edge after rst deasserts SHALL behave as a normal IDLE sample.

Structure
REQ-018 A shared package addsub_pkg SHALL hold:
- the width constant (4)
- the state encoding (IDLE, EXEC, DONE)
- requester-id constants (REQ0 = 0, REQ1 = 1)
REQ-019 The datapath SHALL be one instance of the existing addsub_4 add/subtract unit, fed from the latched operands.
REQ-020 ovf SHALL be derived outside addsub_4; all outputs SHALL be registered.

Verification
REQ-021 req0 only, a0=3, b0=2, as0=0 -> gnt0 in N+1, done0 in N+2, result=5, cout=0, ovf=0.
REQ-022 req1 only, a1=2, b1=3, as1=1 -> done1, result=4'hF, cout=0, ovf=0, busy high N+1..N+2.
REQ-023 After reset, req0 and req1 both held high -> served in order 0, 1, 0, 1; gnt pulses at 3-cycle spacing; never both gnt high.
REQ-024 Overflow cases:
- 7+1 add -> result=8, ovf=1, cout=0
- 8-1 subtract -> result=7, ovf=1, cout=1
- 5-5 -> result=0, cout=1, ovf=0
REQ-025 rst pulse mid-EXEC -> no done, all outputs 0 immediately; a following req0 is served normally with requester-0 priority.
REQ-026 Operands changed in the gnt cycle -> result reflects the values latched at the IDLE edge.
